// File: rtl/mem_tile_feeder_if.sv
// mem_tile_feeder_if: tile-feeder control, memory read port and array lane bundle
interface mem_tile_feeder_if #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [N*DATA_W-1:0] lane_data;
    logic [N-1:0]      lane_valid;
    logic              busy;
    logic              done;
    modport master (output start, base_addr, stride, stall, mem_data,
                    input  mem_addr, lane_data, lane_valid, busy, done);
    modport slave  (input  start, base_addr, stride, stall, mem_data,
                    output mem_addr, lane_data, lane_valid, busy, done);
endinterface

// File: rtl/mem_tile_feeder.sv
// mem_tile_feeder: loads an NxN tile from memory, then streams it diagonally skewed into the array lanes
module mem_tile_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input logic clk,
    input logic rst_n,
    mem_tile_feeder_if.slave bus
);
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int TW = $clog2(2 * N);
    typedef enum logic [1:0] {IDLE, LOAD, FEED, DONE} state_t;
    state_t            st_q, st_d;
    logic [CW-1:0]     row_q, col_q;
    logic [TW-1:0]     t_q;
    logic [ADDR_W-1:0] base_q, stride_q;
    logic [DATA_W-1:0] buf_q [N][N];
    logic [N*DATA_W-1:0] ld;
    logic [N-1:0]      lv;
    logic              last_col, last_rd, last_t;
    assign last_col = col_q == CW'(N - 1);
    assign last_rd  = last_col && row_q == CW'(N - 1);
    assign last_t   = t_q == TW'(2 * N - 2);
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = bus.start ? LOAD : IDLE;
            LOAD:    st_d = last_rd ? FEED : LOAD;
            FEED:    st_d = (!bus.stall && last_t) ? DONE : FEED;
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            t_q      <= '0;
            base_q   <= '0;
            stride_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == IDLE && bus.start) begin
                base_q   <= bus.base_addr;
                stride_q <= bus.stride;
                row_q    <= '0;
                col_q    <= '0;
                t_q      <= '0;
            end
            if (st_q == LOAD) begin
                col_q <= last_col ? '0 : col_q + CW'(1);
                if (last_col)
                    row_q <= last_rd ? '0 : row_q + CW'(1);
            end
            if (st_q == FEED && !bus.stall)
                t_q <= t_q + TW'(1);
        end
    end
    // tile storage carries no reset; it is only ever observed during FEED
    always_ff @(posedge clk) begin
        if (st_q == LOAD)
            buf_q[row_q][col_q] <= bus.mem_data;
    end
    always_comb begin
        ld = '0;
        lv = '0;
        for (int r = 0; r < N; r++) begin
            if (st_q == FEED && int'(t_q) >= r && int'(t_q) - r < N) begin
                lv[r] = 1'b1;
                ld[r*DATA_W +: DATA_W] = buf_q[r][CW'(int'(t_q) - r)];
            end
        end
    end
    assign bus.mem_addr   = st_q == LOAD ? base_q + ADDR_W'(row_q) * stride_q + ADDR_W'(col_q) : '0;
    assign bus.lane_data  = ld;
    assign bus.lane_valid = lv;
    assign bus.busy       = st_q != IDLE;
    assign bus.done       = st_q == DONE;
endmodule
